// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg -- shared types and defaults for the PC sequencing controller.
//   pcc_state_e : controller states (RUN, WAIT, PEND)
//   redir_src_e : redirect sources, encoded so a larger value means higher
//                 priority (TRAP > MRET > BR > JAL > NONE)
//   flush_id_for: whether a redirect from a given source squashes the ID stage
// Optional feature macro used by importers: PC_CTRL_TRAP_EN
package pc_ctrl_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    PEND = 2'd2
  } pcc_state_e;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    JAL  = 3'd1,
    BR   = 3'd2,
    MRET = 3'd3,
    TRAP = 3'd4
  } redir_src_e;

  // A jal resolves in ID, so the ID-stage instruction is the jal itself and
  // must survive; every later-resolving source squashes ID as well.
  function automatic logic flush_id_for(redir_src_e src);
    return (src != NONE) && (src != JAL);
  endfunction

endpackage

// File: rtl/pc_ctrl_redir_arb.sv
// pc_ctrl_redir_arb -- combinational redirect arbiter.
// Picks the highest-priority valid redirect and forms its absolute target
// (base + off, wrapping modulo 2^XLEN). Losing requests are dropped.
// Ports:
//   jal_valid/jal_base/jal_off  in   ID-stage jump request
//   br_valid/br_base/br_off     in   EX-stage taken branch
//   trap_valid, mret_valid      in   (PC_CTRL_TRAP_EN only)
//   epc                         in   mret return address (PC_CTRL_TRAP_EN only)
//   redir_valid                 out  some redirect is requested
//   redir_src                   out  winning source
//   redir_tgt                   out  winning absolute target
// Macro: PC_CTRL_TRAP_EN adds the trap and mret priority levels.
module pc_ctrl_redir_arb
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef PC_CTRL_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_base,
  input  logic [XLEN-1:0] jal_off,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_off,
`ifdef PC_CTRL_TRAP_EN
  input  logic            trap_valid,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] epc,
`endif
  output logic            redir_valid,
  output redir_src_e      redir_src,
  output logic [XLEN-1:0] redir_tgt
);

  always_comb begin
    redir_valid = 1'b0;
    redir_src   = NONE;
    redir_tgt   = '0;
`ifdef PC_CTRL_TRAP_EN
    if (trap_valid) begin
      redir_valid = 1'b1;
      redir_src   = TRAP;
      redir_tgt   = TRAP_VEC;
    end else if (mret_valid) begin
      redir_valid = 1'b1;
      redir_src   = MRET;
      redir_tgt   = epc;
    end else
`endif
    if (br_valid) begin
      redir_valid = 1'b1;
      redir_src   = BR;
      redir_tgt   = br_base + br_off;
    end else if (jal_valid) begin
      redir_valid = 1'b1;
      redir_src   = JAL;
      redir_tgt   = jal_base + jal_off;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl -- program-counter sequencer.
// Holds the PC while a fetch is outstanding, arbitrates redirects, drives the
// pc register's stall/jmp/rel/nxt inputs and the IF/ID flush strobes.
//
//   state | meaning
//   RUN   | fetch in flight, PC advances on each ack
//   WAIT  | ack missing, PC held, no redirect pending
//   PEND  | ack missing, redirect latched in pend_src/pend_tgt
//
// Ports:
//   clk, rst (async, active-low)
//   imem_req out / imem_ack in     instruction-memory handshake
//   hazard_stall in                 hold PC (overridden by redirects)
//   jal_valid/base/off in           ID-stage jump
//   br_valid/base/off in            EX-stage taken branch
//   pc_cur in                       current PC from the pc register
//   pc_stall/pc_jmp/pc_rel/pc_nxt   controls to the pc register
//   flush_if, flush_id out          wrong-path squash strobes
//   trap_valid, trap_pc, mret_valid in; epc out   (PC_CTRL_TRAP_EN only)
// Macro: PC_CTRL_TRAP_EN adds trap entry, mret return and the epc register.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef PC_CTRL_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic            hazard_stall,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_base,
  input  logic [XLEN-1:0] jal_off,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_off,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_stall,
  output logic            pc_jmp,
  output logic            pc_rel,
  output logic [XLEN-1:0] pc_nxt,
  output logic            flush_if,
  output logic            flush_id
`ifdef PC_CTRL_TRAP_EN
  ,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_valid,
  output logic [XLEN-1:0] epc
`endif
);

  pcc_state_e      state, state_nxt;
  redir_src_e      pend_src, pend_src_nxt;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
  logic            redir_valid;
  redir_src_e      redir_src;
  logic [XLEN-1:0] redir_tgt;
  logic            outranks;
`ifdef PC_CTRL_TRAP_EN
  logic            accept;
  logic            epc_ld;
  logic [XLEN-1:0] epc_q;
`endif

  pc_ctrl_redir_arb #(
    .XLEN(XLEN)
`ifdef PC_CTRL_TRAP_EN
    , .TRAP_VEC(TRAP_VEC)
`endif
  ) u_arb (
    .jal_valid  (jal_valid),
    .jal_base   (jal_base),
    .jal_off    (jal_off),
    .br_valid   (br_valid),
    .br_base    (br_base),
    .br_off     (br_off),
`ifdef PC_CTRL_TRAP_EN
    .trap_valid (trap_valid),
    .mret_valid (mret_valid),
    .epc        (epc_q),
`endif
    .redir_valid(redir_valid),
    .redir_src  (redir_src),
    .redir_tgt  (redir_tgt)
  );

  // Only a strictly higher-priority request may replace a pending redirect.
  assign outranks = redir_valid && (redir_src > pend_src);
  assign pc_rel   = 1'b0;

`ifdef PC_CTRL_TRAP_EN
  assign accept = (state == PEND) ? outranks : redir_valid;
  assign epc_ld = accept && (redir_src == TRAP);
  assign epc    = epc_q;
`endif

  always_comb begin
    state_nxt    = state;
    pend_src_nxt = pend_src;
    pend_tgt_nxt = pend_tgt;
    imem_req     = 1'b1;
    pc_stall     = 1'b1;
    pc_jmp       = 1'b0;
    // Idle value is the current PC so pc_nxt never carries a stale target.
    pc_nxt       = pc_cur;
    flush_if     = 1'b0;
    flush_id     = 1'b0;

    unique case (state)
      RUN, WAIT: begin
        if (imem_ack) begin
          state_nxt = RUN;
          if (redir_valid) begin
            pc_stall = 1'b0;
            pc_jmp   = 1'b1;
            pc_nxt   = redir_tgt;
            flush_if = 1'b1;
            flush_id = flush_id_for(redir_src);
          end else if (!hazard_stall) begin
            pc_stall = 1'b0;
          end
        end else if (redir_valid) begin
          pend_src_nxt = redir_src;
          pend_tgt_nxt = redir_tgt;
          flush_id     = flush_id_for(redir_src);
          state_nxt    = PEND;
        end else begin
          state_nxt = WAIT;
        end
      end
      PEND: begin
        if (imem_ack) begin
          // The returned word belongs to the old path, so it is squashed.
          pc_stall     = 1'b0;
          pc_jmp       = 1'b1;
          flush_if     = 1'b1;
          pend_src_nxt = NONE;
          pend_tgt_nxt = '0;
          state_nxt    = RUN;
          if (outranks) begin
            pc_nxt   = redir_tgt;
            flush_id = flush_id_for(redir_src);
          end else begin
            pc_nxt = pend_tgt;
          end
        end else if (outranks) begin
          pend_src_nxt = redir_src;
          pend_tgt_nxt = redir_tgt;
          flush_id     = flush_id_for(redir_src);
        end
      end
      default: state_nxt = RUN;
    endcase

    if (!rst) begin
      imem_req = 1'b0;
      pc_stall = 1'b1;
      pc_jmp   = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      pend_src <= NONE;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      pend_src <= pend_src_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

`ifdef PC_CTRL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q <= '0;
    end else if (epc_ld) begin
      epc_q <= trap_pc;
    end
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl -- scoreboard bench for pc_ctrl.
// The driver applies one directed vector per cycle and queues the expected
// controller response; the monitor pops and compares on every cycle the DUT
// presents a fetch request, and checks the reset output values while in reset.
// A small pc register model closes the loop so pc_cur follows the DUT.
// Macro: PC_CTRL_TRAP_EN enables the trap/mret vectors.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack, hazard_stall;
  logic        jal_valid, br_valid;
  logic [31:0] jal_base, jal_off, br_base, br_off;
  logic [31:0] pc_cur, pc_nxt;
  logic        pc_stall, pc_jmp, pc_rel, flush_if, flush_id;
`ifdef PC_CTRL_TRAP_EN
  logic        trap_valid, mret_valid;
  logic [31:0] trap_pc, epc;
`endif

  always #5 clk = ~clk;

  pc_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .hazard_stall(hazard_stall),
    .jal_valid   (jal_valid),
    .jal_base    (jal_base),
    .jal_off     (jal_off),
    .br_valid    (br_valid),
    .br_base     (br_base),
    .br_off      (br_off),
    .pc_cur      (pc_cur),
    .pc_stall    (pc_stall),
    .pc_jmp      (pc_jmp),
    .pc_rel      (pc_rel),
    .pc_nxt      (pc_nxt),
    .flush_if    (flush_if),
    .flush_id    (flush_id)
`ifdef PC_CTRL_TRAP_EN
    ,
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .mret_valid  (mret_valid),
    .epc         (epc)
`endif
  );

  // pc register model: jmp loads nxt, otherwise advance unless stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pc_cur <= 32'h0;
    else if (pc_jmp)   pc_cur <= pc_nxt;
    else if (!pc_stall) pc_cur <= pc_cur + 32'd4;
  end

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        jmp;
    logic [31:0] nxt;
    logic        fif;
    logic        fid;
    logic [31:0] epc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
        chk("rst_pc_jmp",   {31'b0, pc_jmp},   32'd0);
        chk("rst_flush",    {30'b0, flush_if, flush_id}, 32'd0);
`ifdef PC_CTRL_TRAP_EN
        chk("rst_epc", epc, 32'h0);
`endif
      end else if (imem_req && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_cur",   pc_cur, e.pc);
        chk("pc_stall", {31'b0, pc_stall}, {31'b0, e.stall});
        chk("pc_jmp",   {31'b0, pc_jmp},   {31'b0, e.jmp});
        if (e.jmp) chk("pc_nxt", pc_nxt, e.nxt);
        chk("pc_rel",   {31'b0, pc_rel},   32'd0);
        chk("flush_if", {31'b0, flush_if}, {31'b0, e.fif});
        chk("flush_id", {31'b0, flush_id}, {31'b0, e.fid});
`ifdef PC_CTRL_TRAP_EN
        chk("epc", epc, e.epc);
`endif
      end
    end
  end

  task automatic step(input logic ack, input logic hz,
                      input logic jv, input logic [31:0] jb, input logic [31:0] jo,
                      input logic bv, input logic [31:0] bb, input logic [31:0] bo,
                      input logic tv, input logic [31:0] tpc, input logic mv,
                      input logic [31:0] e_pc, input logic e_stall, input logic e_jmp,
                      input logic [31:0] e_nxt, input logic e_fif, input logic e_fid,
                      input logic [31:0] e_epc);
    exp_t e;
    imem_ack = ack; hazard_stall = hz;
    jal_valid = jv; jal_base = jb; jal_off = jo;
    br_valid = bv;  br_base = bb;  br_off = bo;
`ifdef PC_CTRL_TRAP_EN
    trap_valid = tv; trap_pc = tpc; mret_valid = mv;
`endif
    e.pc = e_pc; e.stall = e_stall; e.jmp = e_jmp; e.nxt = e_nxt;
    e.fif = e_fif; e.fid = e_fid; e.epc = e_epc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

`ifdef PC_CTRL_TRAP_EN
  localparam logic [31:0] PC_BEFORE_RST  = 32'h104;
  localparam logic [31:0] EPC_BEFORE_RST = 32'h48;
`else
  localparam logic [31:0] PC_BEFORE_RST  = 32'h608;
  localparam logic [31:0] EPC_BEFORE_RST = 32'h0;
`endif

  // Driver
  initial begin
    imem_ack = 0; hazard_stall = 0;
    jal_valid = 0; jal_base = 0; jal_off = 0;
    br_valid = 0; br_base = 0; br_off = 0;
`ifdef PC_CTRL_TRAP_EN
    trap_valid = 0; trap_pc = 0; mret_valid = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    //   ack hz  jal          br                   trap    mret  pc    st jmp nxt   fif fid epc
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h000, 0, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h004, 0, 0, 0,     0, 0, 0);
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h008, 1, 0, 0,     0, 0, 0);
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h008, 1, 0, 0,     0, 0, 0);
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h008, 1, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h008, 0, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h00C, 0, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       1, 'h20, 'h40,       0, 0, 0, 'h010, 0, 1, 'h060, 1, 1, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h060, 0, 0, 0,     0, 0, 0);
    // jal pends, br outranks it, a later jal is ignored, ack delivers br target
    step(0, 0, 1, 'h80, 'h80, 0, 0, 0,             0, 0, 0, 'h064, 1, 0, 0,     0, 0, 0);
    step(0, 0, 0, 0, 0,       1, 'h100, 'h100,     0, 0, 0, 'h064, 1, 0, 0,     0, 1, 0);
    step(0, 0, 1, 0, 'h300,   0, 0, 0,             0, 0, 0, 'h064, 1, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h064, 0, 1, 'h200, 1, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h200, 0, 0, 0,     0, 0, 0);
    // branch with hazard, target wraps modulo 2^32
    step(1, 1, 0, 0, 0,       1, 'h204, 'hFFFF_FFFC, 0, 0, 0, 'h204, 0, 1, 'h200, 1, 1, 0);
    step(1, 1, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h200, 1, 0, 0,     0, 0, 0);
    step(1, 0, 1, 'h200, 'h10, 1, 0, 'h400,        0, 0, 0, 'h200, 0, 1, 'h400, 1, 1, 0);
    step(1, 0, 1, 'h400, 'h8, 0, 0, 0,             0, 0, 0, 'h400, 0, 1, 'h408, 1, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h408, 0, 0, 0,     0, 0, 0);
    // WAIT -> PEND (jal), then WAIT with ack redirect
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h40C, 1, 0, 0,     0, 0, 0);
    step(0, 0, 1, 'h500, 0,   0, 0, 0,             0, 0, 0, 'h40C, 1, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h40C, 0, 1, 'h500, 1, 0, 0);
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h500, 1, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       1, 'h500, 'h20,      0, 0, 0, 'h500, 0, 1, 'h520, 1, 1, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h520, 0, 0, 0,     0, 0, 0);
    // pending br, lower-priority jal on the ack cycle is dropped
    step(0, 0, 0, 0, 0,       1, 'h600, 0,         0, 0, 0, 'h524, 1, 0, 0,     0, 1, 0);
    step(1, 0, 1, 'h700, 0,   0, 0, 0,             0, 0, 0, 'h524, 0, 1, 'h600, 1, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h600, 0, 0, 0,     0, 0, 0);
    // WAIT, ack arrives with hazard: stays stalled
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h604, 1, 0, 0,     0, 0, 0);
    step(1, 1, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h604, 1, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h604, 0, 0, 0,     0, 0, 0);
`ifdef PC_CTRL_TRAP_EN
    // trap beats br; mret returns to epc; pending mret outranked by trap
    step(1, 0, 0, 0, 0,       1, 0, 'h900,         1, 'h44, 0, 'h608, 0, 1, 'h100, 1, 1, 'h00);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h100, 0, 0, 0,     0, 0, 'h44);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 1, 'h104, 0, 1, 'h044, 1, 1, 'h44);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h044, 0, 0, 0,     0, 0, 'h44);
    step(0, 0, 0, 0, 0,       0, 0, 0,             0, 0, 1, 'h048, 1, 0, 0,     0, 1, 'h44);
    step(0, 0, 0, 0, 0,       0, 0, 0,             1, 'h48, 1, 'h048, 1, 0, 0,    0, 1, 'h44);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h048, 0, 1, 'h100, 1, 0, 'h48);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h100, 0, 0, 0,     0, 0, 'h48);
`endif
    // async reset while a br is pending discards it
    step(0, 0, 0, 0, 0,       1, 0, 'h800,         0, 0, 0, PC_BEFORE_RST, 1, 0, 0, 0, 1, EPC_BEFORE_RST);
    rst = 1'b0;
    imem_ack = 0; br_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h000, 0, 0, 0,     0, 0, 0);
    step(1, 0, 0, 0, 0,       0, 0, 0,             0, 0, 0, 'h004, 0, 0, 0,     0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
